pe_serial_feeder: RTL and testbench
===================================

Name: pe_serial_feeder

Overview:
Upstream sequencer for one bit-serial multiply-accumulate PE. It accepts parallel weight words (6-bit sign-magnitude) and parallel sample pairs (X 8-bit, Y 16-bit) over valid/ready handshakes. It serializes them LSB-first onto the PE's shared xOrW line and its yIn line, and generates the PE's 3-bit control word cycle by cycle. One sample frame is 16 cycles: 8 X/Y bits, then 8 Y-only bits.

Parameters:
W_BITS, 6, weight word width (bit 5 = sign, bits 4:0 = magnitude); only the default is supported.
X_BITS, 8, X sample width; only the default is supported.
Y_BITS, 16, partial-sum width and frame length in cycles; must equal 2*X_BITS.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
w_data  input  6  weight word to load
w_valid  input  1  w_data is valid
w_ready  output  1  feeder accepts a weight this cycle
x_data  input  8  X sample
y_data  input  16  incoming partial sum Y
xy_valid  input  1  x_data/y_data are valid
xy_ready  output  1  feeder accepts a sample pair this cycle
xOrW  output  1  serial X or W bit to the PE
yIn  output  1  serial Y bit to the PE
ctrl  output  3  PE control: [2] = LSB-of-X marker, [1] = circulate/hold, [0] = load W
frame_done  output  1  one-cycle pulse on the last Y bit of a frame
busy  output  1  high whenever state is not IDLE

Behaviour:
- Registers:
  - All outputs are registered (driven from flops); w_ready, xy_ready and busy are decoded from the state/counter registers.
  - State register: IDLE, LOAD_W, X_PH, Y_PH.
  - 4-bit bit counter cnt.
  - w_loaded flag.
  - Shift copies of the accepted words.
- Reset (asynchronous, when reset = 0):
  - State = IDLE, cnt = 0, w_loaded = 0, frame_done = 0.
  - xOrW = 0, yIn = 0, ctrl = 3'b010 (PE holds its delay lines and its X/W mux forces 0).
  - Reset asserted mid-frame aborts the frame immediately. No partial-frame completion; no frame_done.
- Idle drive: xOrW = 0, yIn = 0, ctrl = 010.
- Handshake: a transfer occurs on a rising edge where valid & ready. Data is sampled at that edge, and the first serial bit appears on the outputs in the following cycle (latency 1).
- Ready decode:
  - w_ready = 1 in IDLE, and in Y_PH when cnt = 15.
  - xy_ready = w_loaded & ~(w_valid) under the same state conditions.
  - Weight takes priority. If w_valid and xy_valid are both high, only the weight transfers.
- IDLE:
  - On a weight transfer → LOAD_W, cnt = 0.
  - On a sample transfer → X_PH, cnt = 0.
- LOAD_W (6 cycles, cnt 0..5):
  - xOrW = w[cnt], yIn = 0, ctrl = 001.
  - After cnt = 5: w_loaded <= 1, then → IDLE.
  - The ready signals are 0 in this state; there are no back-to-back weight loads without an IDLE cycle.
- X_PH (cnt 0..7):
  - xOrW = x[cnt], yIn = y[cnt].
  - ctrl = 100 when cnt = 0, otherwise 000.
  - After cnt = 7 → Y_PH.
- Y_PH (cnt 8..15):
  - xOrW = 0, yIn = y[cnt], ctrl = 010.
  - At cnt = 15, frame_done = 1. In the same cycle:
    - if a weight transfer occurs → LOAD_W, cnt = 0;
    - else if a sample transfer occurs → X_PH, cnt = 0 (zero-bubble back-to-back frames);
    - otherwise → IDLE.
- cnt wraps 15 → 0 only via these transitions; it never free-runs.
- Inputs are ignored whenever ready = 0. Holding valid high with ready low causes no transfer and no state change.
- A new weight may be loaded between any two frames. The frames before it use the old weight, the frames after it use the new one.

Test Plan:
1. Reset release, then w_data = 6'b101000 with w_valid for one cycle → next 6 cycles: xOrW = 0,0,0,1,0,1 and ctrl = 001 each cycle; then idle drive (ctrl = 010, xOrW = 0); w_loaded set.
2. After the weight load, x_data = 8'b10110101, y_data = 16'b0101110111001101, one xy_valid pulse:
   - next 16 cycles: ctrl = 100 then 000×7 then 010×8;
   - xOrW = 1,0,1,0,1,1,0,1 followed by 0×8;
   - yIn = Y bits 0..15;
   - frame_done high only in cycle 16.
3. xy_valid held high with X = 240, Y = 43690, then X = 181, Y = 24013 queued → the second frame's ctrl = 100 appears in the cycle immediately after the first frame's last bit (no bubble); two frame_done pulses 16 cycles apart.
4. xy_valid asserted before any weight load → xy_ready stays 0 and outputs stay in idle drive; after a weight load, the sample is accepted.
5. At cnt = 15, w_valid and xy_valid both high → the weight is accepted (ctrl = 001 for the next 6 cycles) and xy_ready = 0; the sample is accepted later, from IDLE.
6. reset driven low at X_PH cnt = 4 → outputs go to 0/0/010 without waiting for a clock edge; no frame_done; w_loaded = 0; xy_ready = 0 after release.

Source files
------------

// File: rtl/pe_serial_feeder.sv
// Sequencer for one bit-serial MAC PE: accepts weight words and X/Y sample
// pairs, shifts them out LSB-first and drives the PE control word per cycle.
module pe_serial_feeder #(
  parameter int W_BITS = 6,
  parameter int X_BITS = 8,
  parameter int Y_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W_BITS-1:0] w_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [X_BITS-1:0] x_data,
  input  logic [Y_BITS-1:0] y_data,
  input  logic              xy_valid,
  output logic              xy_ready,
  output logic              xOrW,
  output logic              yIn,
  output logic [2:0]        ctrl,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOAD_W, X_PH, Y_PH} state_t;

  localparam logic [2:0] CTRL_LOADW = 3'b001;
  localparam logic [2:0] CTRL_HOLD  = 3'b010;
  localparam logic [2:0] CTRL_XLSB  = 3'b100;
  localparam logic [2:0] CTRL_RUN   = 3'b000;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              w_loaded_reg, w_loaded_next;
  logic [W_BITS-1:0] w_word_reg, w_word_next;
  logic [X_BITS-1:0] x_word_reg, x_word_next;
  logic [Y_BITS-1:0] y_word_reg, y_word_next;

  logic              x_or_w_reg, x_or_w_next;
  logic              y_in_reg, y_in_next;
  logic [2:0]        ctrl_reg, ctrl_next;
  logic              frame_done_reg, frame_done_next;

  logic              slot_open;
  logic              w_xfer;
  logic              xy_xfer;

  // New work is taken only when idle or on the last Y bit of a frame.
  assign slot_open = (state_reg == IDLE) || ((state_reg == Y_PH) && (cnt_reg == 4'd15));
  assign w_ready   = slot_open;
  assign xy_ready  = slot_open & w_loaded_reg & ~w_valid;
  assign w_xfer    = w_valid & w_ready;
  assign xy_xfer   = xy_valid & xy_ready;
  assign busy      = (state_reg != IDLE);

  assign xOrW       = x_or_w_reg;
  assign yIn        = y_in_reg;
  assign ctrl       = ctrl_reg;
  assign frame_done = frame_done_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      w_loaded_reg   <= 1'b0;
      w_word_reg     <= '0;
      x_word_reg     <= '0;
      y_word_reg     <= '0;
      x_or_w_reg     <= 1'b0;
      y_in_reg       <= 1'b0;
      ctrl_reg       <= CTRL_HOLD;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      w_loaded_reg   <= w_loaded_next;
      w_word_reg     <= w_word_next;
      x_word_reg     <= x_word_next;
      y_word_reg     <= y_word_next;
      x_or_w_reg     <= x_or_w_next;
      y_in_reg       <= y_in_next;
      ctrl_reg       <= ctrl_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    w_loaded_next = w_loaded_reg;
    w_word_next   = w_xfer  ? w_data : w_word_reg;
    x_word_next   = xy_xfer ? x_data : x_word_reg;
    y_word_next   = xy_xfer ? y_data : y_word_reg;
    case (state_reg)
      IDLE: begin
        if (w_xfer) begin
          state_next = LOAD_W;
          cnt_next   = 4'd0;
        end else if (xy_xfer) begin
          state_next = X_PH;
          cnt_next   = 4'd0;
        end
      end
      LOAD_W: begin
        if (cnt_reg == 4'd5) begin
          state_next    = IDLE;
          cnt_next      = 4'd0;
          w_loaded_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      X_PH: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd7) state_next = Y_PH;
      end
      Y_PH: begin
        if (cnt_reg == 4'd15) begin
          cnt_next = 4'd0;
          if (w_xfer)       state_next = LOAD_W;
          else if (xy_xfer) state_next = X_PH;
          else              state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Outputs are computed from the next state so the first bit appears one cycle after the transfer.
  always_comb begin
    x_or_w_next     = 1'b0;
    y_in_next       = 1'b0;
    ctrl_next       = CTRL_HOLD;
    frame_done_next = 1'b0;
    case (state_next)
      LOAD_W: begin
        x_or_w_next = w_word_next[cnt_next[2:0]];
        ctrl_next   = CTRL_LOADW;
      end
      X_PH: begin
        x_or_w_next = x_word_next[cnt_next[2:0]];
        y_in_next   = y_word_next[cnt_next];
        ctrl_next   = (cnt_next == 4'd0) ? CTRL_XLSB : CTRL_RUN;
      end
      Y_PH: begin
        y_in_next       = y_word_next[cnt_next];
        frame_done_next = (cnt_next == 4'd15);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_serial_feeder.sv
// Bench for pe_serial_feeder: directed scenarios plus random traffic, checked
// against a queue of expected per-cycle outputs built from the frame rules.
module tb_pe_serial_feeder;

  logic        clk;
  logic        reset;
  logic [5:0]  w_data;
  logic        w_valid;
  logic        w_ready;
  logic [7:0]  x_data;
  logic [15:0] y_data;
  logic        xy_valid;
  logic        xy_ready;
  logic        xOrW;
  logic        yIn;
  logic [2:0]  ctrl;
  logic        frame_done;
  logic        busy;

  pe_serial_feeder dut (
    .clk(clk), .reset(reset),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .x_data(x_data), .y_data(y_data), .xy_valid(xy_valid), .xy_ready(xy_ready),
    .xOrW(xOrW), .yIn(yIn), .ctrl(ctrl), .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       x;
    logic       y;
    logic [2:0] c;
    logic       fd;
  } ent_t;

  ent_t q[$];
  bit   w_loaded_m;
  int   checks;
  int   errors;
  int   cyc;

  logic       obs_x, obs_y, obs_fd, obs_xyr, obs_wr;
  logic [2:0] obs_ctrl;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input logic wv, input logic [5:0] wd, input logic xv,
                      input logic [7:0] xd, input logic [15:0] yd);
    ent_t e;
    logic er, exr, wx, xx;
    e = (q.size() > 0) ? q[0] : ent_t'({1'b0, 1'b0, 3'b010, 1'b0});
    obs_x = xOrW; obs_y = yIn; obs_ctrl = ctrl; obs_fd = frame_done;
    check_eq("xOrW", {15'd0, xOrW}, {15'd0, e.x});
    check_eq("yIn", {15'd0, yIn}, {15'd0, e.y});
    check_eq("ctrl", {13'd0, ctrl}, {13'd0, e.c});
    check_eq("frame_done", {15'd0, frame_done}, {15'd0, e.fd});
    check_eq("busy", {15'd0, busy}, {15'd0, q.size() != 0});
    w_valid = wv; w_data = wd; xy_valid = xv; x_data = xd; y_data = yd;
    #1;
    er  = (q.size() == 0) || (q.size() == 1 && q[0].fd);
    exr = er && w_loaded_m && !wv;
    obs_xyr = xy_ready; obs_wr = w_ready;
    check_eq("w_ready", {15'd0, w_ready}, {15'd0, er});
    check_eq("xy_ready", {15'd0, xy_ready}, {15'd0, exr});
    wx = er && wv;
    xx = exr && xv;
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    if (wx) begin
      for (int i = 0; i < 6; i++) q.push_back(ent_t'({wd[i], 1'b0, 3'b001, 1'b0}));
      w_loaded_m = 1'b1;
    end else if (xx) begin
      for (int i = 0; i < 16; i++) begin
        e.x  = (i < 8) ? xd[i] : 1'b0;
        e.y  = yd[i];
        e.c  = (i == 0) ? 3'b100 : ((i < 8) ? 3'b000 : 3'b010);
        e.fd = (i == 15);
        q.push_back(e);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_step();
    step(1'b0, 6'd0, 1'b0, 8'd0, 16'd0);
  endtask

  initial begin
    logic [5:0]  wlit;
    logic [7:0]  xlit;
    logic [15:0] ylit;
    checks = 0; errors = 0; cyc = 0; w_loaded_m = 1'b0;
    reset = 1'b0; w_valid = 1'b0; w_data = '0; xy_valid = 1'b0; x_data = '0; y_data = '0;

    // Reset state
    #12;
    check_eq("rst_xOrW", {15'd0, xOrW}, 16'd0);
    check_eq("rst_yIn", {15'd0, yIn}, 16'd0);
    check_eq("rst_ctrl", {13'd0, ctrl}, 16'd2);
    check_eq("rst_fd", {15'd0, frame_done}, 16'd0);
    check_eq("rst_busy", {15'd0, busy}, 16'd0);
    check_eq("rst_xy_ready", {15'd0, xy_ready}, 16'd0);
    @(negedge clk);
    reset = 1'b1;

    // Samples offered before any weight are refused
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 6'd0, 1'b1, 8'hA5, 16'h1234);
      check_eq("t4_xy_ready", {15'd0, obs_xyr}, 16'd0);
      check_eq("t4_ctrl", {13'd0, obs_ctrl}, 16'd2);
    end

    // Weight load
    wlit = 6'b101000;
    step(1'b1, wlit, 1'b0, 8'd0, 16'd0);
    for (int i = 0; i < 6; i++) begin
      idle_step();
      check_eq("t1_w_bit", {15'd0, obs_x}, {15'd0, wlit[i]});
      check_eq("t1_ctrl", {13'd0, obs_ctrl}, 16'd1);
    end
    idle_step();
    check_eq("t1_idle_ctrl", {13'd0, obs_ctrl}, 16'd2);

    // Single frame
    xlit = 8'b10110101; ylit = 16'b0101110111001101;
    step(1'b0, 6'd0, 1'b1, xlit, ylit);
    for (int i = 0; i < 16; i++) begin
      idle_step();
      check_eq("t2_x", {15'd0, obs_x}, (i < 8) ? {15'd0, xlit[i]} : 16'd0);
      check_eq("t2_y", {15'd0, obs_y}, {15'd0, ylit[i]});
      check_eq("t2_fd", {15'd0, obs_fd}, (i == 15) ? 16'd1 : 16'd0);
    end

    // Back-to-back frames with xy_valid held
    step(1'b0, 6'd0, 1'b1, 8'd240, 16'd43690);
    for (int i = 0; i < 15; i++) step(1'b0, 6'd0, 1'b1, 8'd240, 16'd43690);
    step(1'b0, 6'd0, 1'b1, 8'd181, 16'd24013);
    check_eq("t3_fd1", {15'd0, obs_fd}, 16'd1);
    check_eq("t3_accept", {15'd0, obs_xyr}, 16'd1);
    idle_step();
    check_eq("t3_nobubble", {13'd0, obs_ctrl}, 16'd4);
    check_eq("t3_x0", {15'd0, obs_x}, 16'd1);
    for (int i = 1; i < 16; i++) idle_step();
    check_eq("t3_fd2", {15'd0, obs_fd}, 16'd1);

    // Weight wins over sample at the frame boundary
    step(1'b0, 6'd0, 1'b1, 8'h3C, 16'hBEEF);
    for (int i = 0; i < 15; i++) idle_step();
    step(1'b1, 6'b010110, 1'b1, 8'h5A, 16'h0F0F);
    check_eq("t5_fd", {15'd0, obs_fd}, 16'd1);
    check_eq("t5_xy_ready", {15'd0, obs_xyr}, 16'd0);
    check_eq("t5_w_ready", {15'd0, obs_wr}, 16'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 6'd0, 1'b1, 8'h5A, 16'h0F0F);
      check_eq("t5_ctrl", {13'd0, obs_ctrl}, 16'd1);
    end
    step(1'b0, 6'd0, 1'b1, 8'h5A, 16'h0F0F);
    check_eq("t5_idle_accept", {15'd0, obs_xyr}, 16'd1);
    idle_step();
    check_eq("t5_frame_start", {13'd0, obs_ctrl}, 16'd4);
    for (int i = 0; i < 40 && q.size() != 0; i++) idle_step();

    // Asynchronous reset in the middle of X phase
    step(1'b0, 6'd0, 1'b1, 8'hFF, 16'hFFFF);
    for (int i = 0; i < 4; i++) idle_step();
    check_eq("t6_pre_ctrl", {13'd0, ctrl}, 16'd0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_xOrW", {15'd0, xOrW}, 16'd0);
    check_eq("t6_yIn", {15'd0, yIn}, 16'd0);
    check_eq("t6_ctrl", {13'd0, ctrl}, 16'd2);
    check_eq("t6_fd", {15'd0, frame_done}, 16'd0);
    check_eq("t6_busy", {15'd0, busy}, 16'd0);
    q.delete();
    w_loaded_m = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 6'd0, 1'b1, 8'h11, 16'h2222);
    check_eq("t6_xy_ready", {15'd0, obs_xyr}, 16'd0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 15) == 0), 6'($urandom), 1'($urandom_range(0, 1)),
           8'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) idle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
